poly_sq_loop_ctrl: RTL and testbench

Iteration controller that drives the polynomial modular squarer in a closed loop for VDF evaluation. It accepts a seed value in redundant coefficient form and an iteration count T. It issues T back-to-back modular squarings, feeding each result back as the next operand, and returns the final residue through a valid/ready output. The multiplier sits beside this block and is connected through its request/response ports. A top-level wrapper (vdf_sq_top) instantiates both.

---
 rtl/vdf_pkg.sv | 31 +++
 rtl/poly_sq_loop_ctrl.sv | 117 +++++++++++
 tb/tb_poly_sq_loop_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vdf_pkg.sv
// Shared types and sizing helpers for the VDF squaring loop.
// Holds the loop FSM state type and the coefficient vector layout.
package vdf_pkg;

  localparam int WORD_BITS       = 8;
  localparam int NUM_WORDS       = 4;
  localparam int REDUN_WORD_BITS = 1;

  function automatic int calc_i_word(input int num_words);
    return num_words + 1;
  endfunction

  function automatic int calc_coef_bits(input int word_bits,
                                        input int redun_bits);
    return word_bits + redun_bits;
  endfunction

  localparam int I_WORD    = calc_i_word(NUM_WORDS);
  localparam int COEF_BITS = calc_coef_bits(WORD_BITS,
                                            REDUN_WORD_BITS);

  typedef logic [I_WORD-1:0][COEF_BITS-1:0] coeff_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } loop_state_t;

endpackage

// File: rtl/poly_sq_loop_ctrl.sv
// Closed-loop iteration controller for the modular squarer (VDF eval).
// Ports: i_val/o_rdy/i_dat/i_iter start job; o_mul_*/i_mul_* squarer
// link; o_val/i_rdy/o_dat result; o_iter_cnt progress; o_err sticky.
module poly_sq_loop_ctrl
  import vdf_pkg::*;
#(
  parameter  int WORD_BITS       = 8,
  parameter  int NUM_WORDS       = 4,
  parameter  int REDUN_WORD_BITS = 1,
  parameter  int ITER_BITS       = 32,
  parameter  int TIMEOUT         = 64,
  localparam int I_WORD          = calc_i_word(NUM_WORDS),
  localparam int COEF_BITS       = calc_coef_bits(WORD_BITS,
                                                  REDUN_WORD_BITS),
  localparam int DW              = I_WORD * COEF_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_val,
  output logic                 o_rdy,
  input  logic [DW-1:0]        i_dat,
  input  logic [ITER_BITS-1:0] i_iter,
  output logic                 o_mul_val,
  output logic [DW-1:0]        o_mul_dat,
  input  logic                 i_mul_val,
  input  logic [DW-1:0]        i_mul_dat,
  output logic                 o_val,
  input  logic                 i_rdy,
  output logic [DW-1:0]        o_dat,
  output logic [ITER_BITS-1:0] o_iter_cnt,
  output logic                 o_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  loop_state_t          state;
  logic [ITER_BITS-1:0] rem;
  logic [TW-1:0]        tmo;
  logic [TW-1:0]        tmo_nxt;

  assign o_rdy = (state == IDLE);

  // Counts cycles since the issue pulse; holds at TIMEOUT.
  assign tmo_nxt = (tmo == TW'(TIMEOUT)) ? tmo : tmo + TW'(1);

  // o_mul_dat doubles as the operand register: it is loaded on the
  // edge entering ISSUE so the request pulse and its data line up.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      rem        <= '0;
      tmo        <= '0;
      o_mul_val  <= 1'b0;
      o_mul_dat  <= '0;
      o_val      <= 1'b0;
      o_dat      <= '0;
      o_iter_cnt <= '0;
      o_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_val) begin
            o_mul_dat  <= i_dat;
            rem        <= i_iter;
            o_iter_cnt <= '0;
            o_err      <= 1'b0;
            tmo        <= '0;
            if (i_iter == '0) begin
              o_dat <= i_dat;
              o_val <= 1'b1;
              state <= DONE;
            end else begin
              o_mul_val <= 1'b1;
              state     <= ISSUE;
            end
          end
          if (i_mul_val) o_err <= 1'b1;
        end
        ISSUE: begin
          o_mul_val <= 1'b0;
          tmo       <= tmo_nxt;
          state     <= WAIT;
          if (i_mul_val) o_err <= 1'b1;
        end
        WAIT: begin
          if (i_mul_val) begin
            o_iter_cnt <= o_iter_cnt + ITER_BITS'(1);
            rem        <= rem - ITER_BITS'(1);
            tmo        <= '0;
            if (rem == ITER_BITS'(1)) begin
              o_dat <= i_mul_dat;
              o_val <= 1'b1;
              state <= DONE;
            end else begin
              o_mul_dat <= i_mul_dat;
              o_mul_val <= 1'b1;
              state     <= ISSUE;
            end
          end else if (tmo_nxt == TW'(TIMEOUT)) begin
            o_err <= 1'b1;
            state <= IDLE;
          end else begin
            tmo <= tmo_nxt;
          end
        end
        DONE: begin
          if (i_rdy) begin
            o_val <= 1'b0;
            state <= IDLE;
          end
          if (i_mul_val) o_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sq_loop_ctrl.sv
// Directed bench for poly_sq_loop_ctrl with a latency-6 squarer model
// computing x^2 mod 128 in canonical form.
module tb_poly_sq_loop_ctrl;

  localparam int DW = 45;
  localparam int IB = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_val;
  logic          o_rdy;
  logic [DW-1:0] i_dat;
  logic [IB-1:0] i_iter;
  logic          o_mul_val;
  logic [DW-1:0] o_mul_dat;
  logic          i_mul_val;
  logic [DW-1:0] i_mul_dat;
  logic          o_val;
  logic          i_rdy;
  logic [DW-1:0] o_dat;
  logic [IB-1:0] o_iter_cnt;
  logic          o_err;

  poly_sq_loop_ctrl dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_val      (i_val),
    .o_rdy      (o_rdy),
    .i_dat      (i_dat),
    .i_iter     (i_iter),
    .o_mul_val  (o_mul_val),
    .o_mul_dat  (o_mul_dat),
    .i_mul_val  (i_mul_val),
    .i_mul_dat  (i_mul_dat),
    .o_val      (o_val),
    .i_rdy      (i_rdy),
    .o_dat      (o_dat),
    .o_iter_cnt (o_iter_cnt),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  logic [5:0]    vpipe;
  logic [DW-1:0] dpipe [6];
  int            req_cnt;
  int            drop_idx = 0;
  logic          inj = 1'b0;

  function automatic logic [DW-1:0] sq(input logic [DW-1:0] d);
    longint unsigned v;
    v = 0;
    for (int k = 0; k < 5; k++)
      v += longint'(d[k*9 +: 9]) << (8 * k);
    return DW'((v * v) % 128);
  endfunction

  always @(posedge i_clk) begin
    if (i_rst) begin
      vpipe   <= '0;
      req_cnt <= 0;
      for (int k = 0; k < 6; k++) dpipe[k] <= '0;
    end else begin
      vpipe[0] <= o_mul_val &&
                  !(drop_idx != 0 && req_cnt + 1 == drop_idx);
      dpipe[0] <= sq(o_mul_dat);
      for (int k = 1; k < 6; k++) begin
        vpipe[k] <= vpipe[k-1];
        dpipe[k] <= dpipe[k-1];
      end
      if (i_val && o_rdy) req_cnt <= 0;
      else if (o_mul_val) req_cnt <= req_cnt + 1;
    end
  end

  assign i_mul_val = vpipe[5] | inj;
  assign i_mul_dat = dpipe[5];

  int total  = 0;
  int passed = 0;
  int k;
  int pulses;
  int first_p;
  int last_p;
  bit val_seen;
  bit hold_ok;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge i_clk);
    k++;
    if (o_mul_val) begin
      pulses++;
      if (first_p == 0) first_p = k;
      last_p = k;
    end
    if (o_val) val_seen = 1'b1;
  endtask

  task automatic start(input logic [DW-1:0] d, input logic [IB-1:0] t);
    i_val    = 1'b1;
    i_dat    = d;
    i_iter   = t;
    k        = 0;
    pulses   = 0;
    first_p  = 0;
    last_p   = 0;
    val_seen = 1'b0;
    tick();
    i_val = 1'b0;
  endtask

  task automatic wait_val();
    while (!o_val && k < 300) tick();
  endtask

  task automatic drain(input string tag);
    tick();
    chk({tag, "_idle_val"}, 64'(o_val), 64'd0);
    chk({tag, "_idle_rdy"}, 64'(o_rdy), 64'd1);
  endtask

  initial begin
    i_rst  = 1'b1;
    i_val  = 1'b0;
    i_dat  = '0;
    i_iter = '0;
    i_rdy  = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_rdy", 64'(o_rdy), 64'd1);
    chk("rst_val", 64'(o_val), 64'd0);
    chk("rst_mval", 64'(o_mul_val), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_cnt", 64'(o_iter_cnt), 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    start(DW'(3), 32'd1);
    chk("t1_pulse1", 64'(o_mul_val), 64'd1);
    chk("t1_mdat", 64'(o_mul_dat), 64'd3);
    chk("t1_busy", 64'(o_rdy), 64'd0);
    wait_val();
    chk("t1_lat", 64'(k), 64'd8);
    chk("t1_pulses", 64'(pulses), 64'd1);
    chk("t1_dat", 64'(o_dat), 64'd9);
    chk("t1_cnt", 64'(o_iter_cnt), 64'd1);
    drain("t1");

    start(DW'(3), 32'd3);
    wait_val();
    chk("t3_lat", 64'(k), 64'd22);
    chk("t3_pulses", 64'(pulses), 64'd3);
    chk("t3_first", 64'(first_p), 64'd1);
    chk("t3_last", 64'(last_p), 64'd15);
    chk("t3_dat", 64'(o_dat), 64'd33);
    chk("t3_cnt", 64'(o_iter_cnt), 64'd3);
    drain("t3");

    start(DW'(5), 32'd0);
    chk("t0_lat", 64'(o_val), 64'd1);
    chk("t0_nopulse", 64'(o_mul_val), 64'd0);
    chk("t0_dat", 64'(o_dat), 64'd5);
    chk("t0_cnt", 64'(o_iter_cnt), 64'd0);
    drain("t0");

    start(45'h1_2345_6789_AB, 32'd0);
    chk("redun_pass", 64'(o_dat), 64'h1_2345_6789_AB);
    drain("redun");

    i_rdy = 1'b0;
    start(DW'(3), 32'd2);
    tick();
    chk("busy_rdy", 64'(o_rdy), 64'd0);
    i_val  = 1'b1;
    i_dat  = DW'(7);
    i_iter = 32'd0;
    tick();
    i_val = 1'b0;
    wait_val();
    chk("t2_lat", 64'(k), 64'd15);
    chk("t2_dat", 64'(o_dat), 64'd81);
    chk("t2_cnt", 64'(o_iter_cnt), 64'd2);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(o_val === 1'b1 && o_dat === DW'(81))) hold_ok = 1'b0;
    end
    chk("t2_hold", 64'(hold_ok), 64'd1);
    chk("t2_hold_rdy", 64'(o_rdy), 64'd0);
    i_rdy = 1'b1;
    drain("t2");

    drop_idx = 2;
    start(DW'(3), 32'd4);
    while (!o_err && k < 300) tick();
    chk("tmo_at", 64'(k), 64'd72);
    chk("tmo_pulses", 64'(pulses), 64'd2);
    chk("tmo_noval", 64'(val_seen), 64'd0);
    chk("tmo_rdy", 64'(o_rdy), 64'd1);
    drop_idx = 0;
    start(DW'(5), 32'd1);
    chk("tmo_clr", 64'(o_err), 64'd0);
    wait_val();
    chk("tmo_next_dat", 64'(o_dat), 64'd25);
    drain("tmo");

    start(DW'(3), 32'd5);
    while (k < 9) tick();
    chk("rst_mid_cnt", 64'(o_iter_cnt), 64'd1);
    i_rst = 1'b1;
    tick();
    chk("rstm_rdy", 64'(o_rdy), 64'd1);
    chk("rstm_mval", 64'(o_mul_val), 64'd0);
    chk("rstm_mdat", 64'(o_mul_dat), 64'd0);
    chk("rstm_dat", 64'(o_dat), 64'd0);
    chk("rstm_cnt", 64'(o_iter_cnt), 64'd0);
    chk("rstm_val", 64'(o_val), 64'd0);
    i_rst = 1'b0;
    val_seen = 1'b0;
    repeat (12) tick();
    chk("rstm_quiet", 64'(val_seen), 64'd0);
    chk("rstm_err", 64'(o_err), 64'd0);

    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("inj_err", 64'(o_err), 64'd1);
    chk("inj_rdy", 64'(o_rdy), 64'd1);
    tick();
    chk("inj_sticky", 64'(o_err), 64'd1);
    chk("inj_noval", 64'(o_val), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
